// File: rtl/upsample_ctrl_param.sv
// Address/strobe sequencer for 2x nearest-neighbour upsampling of a CH x IMG_H x IMG_W
// feature map: one input read per pixel, then four output writes (one per sub-pixel).
module upsample_ctrl_param #(
   parameter  int unsigned IMG_W  = 4,
   parameter  int unsigned IMG_H  = 4,
   parameter  int unsigned CH     = 2,
   localparam int unsigned IN_AW  = ($clog2(CH*IMG_W*IMG_H) > 1) ? $clog2(CH*IMG_W*IMG_H) : 1,
   localparam int unsigned OUT_AW = IN_AW + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              in_rd_en,
   output logic [IN_AW-1:0]  in_addr,
   output logic              out_wr_en,
   output logic [OUT_AW-1:0] out_addr,
   output logic [1:0]        quad
);

   localparam int unsigned PLANE = IMG_W * IMG_H;
   localparam int unsigned CW    = (CH    > 1) ? $clog2(CH)    : 1;
   localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned WW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic [RW-1:0]   r_q, r_d;
   logic [WW-1:0]   c_q, c_d;
   logic [1:0]      quad_q, quad_d;
   logic            last_px;

   // State and pixel/sub-pixel counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         r_q     <= '0;
         c_q     <= '0;
         quad_q  <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         r_q     <= r_d;
         c_q     <= c_d;
         quad_q  <= quad_d;
      end
   end

   // Next state; counters return to zero after the last pixel so IDLE/FIN show address 0
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      r_d     = r_q;
      c_d     = c_q;
      quad_d  = quad_q;
      last_px = (ch_q == CW'(CH - 1)) && (r_q == RW'(IMG_H - 1)) && (c_q == WW'(IMG_W - 1));
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD;
               ch_d    = '0;
               r_d     = '0;
               c_d     = '0;
               quad_d  = '0;
            end
         end
         S_RD: begin
            state_d = S_WR;
            quad_d  = '0;
         end
         S_WR: begin
            if (out_ready) begin
               quad_d = quad_q + 2'd1;
               if (quad_q == 2'd3) begin
                  if (last_px) begin
                     state_d = S_FIN;
                     ch_d    = '0;
                     r_d     = '0;
                     c_d     = '0;
                  end else begin
                     state_d = S_RD;
                     if (c_q == WW'(IMG_W - 1)) begin
                        c_d = '0;
                        if (r_q == RW'(IMG_H - 1)) begin
                           r_d  = '0;
                           ch_d = ch_q + CW'(1);
                        end else begin
                           r_d = r_q + RW'(1);
                        end
                     end else begin
                        c_d = c_q + WW'(1);
                     end
                  end
               end
            end
         end
         S_FIN: state_d = S_IDLE;
      endcase
   end

   // Strobes and addresses decoded from state; out_wr_en follows out_ready within WR
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FIN);
      in_rd_en  = (state_q == S_RD);
      out_wr_en = (state_q == S_WR) && out_ready;
      quad      = quad_q;
      in_addr   = IN_AW'(32'(ch_q) * PLANE + 32'(r_q) * IMG_W + 32'(c_q));
      out_addr  = OUT_AW'(32'(ch_q) * (4 * PLANE)
                        + (32'(r_q) * 32'd2 + 32'(quad_q[1])) * (2 * IMG_W)
                        + 32'(c_q) * 32'd2 + 32'(quad_q[0]));
   end

endmodule

// File: tb/tb_upsample_ctrl_param.sv
// Directed bench for upsample_ctrl_param: default geometry, 3x2x1 and 1x1x1 instances.
module tb_upsample_ctrl_param;

   logic clk = 1'b0;
   logic rst, out_ready, start_a, start_b, start_c;

   logic busy_a, done_a, in_rd_en_a, out_wr_en_a;
   logic [4:0] in_addr_a;
   logic [6:0] out_addr_a;
   logic [1:0] quad_a;

   logic busy_b, done_b, in_rd_en_b, out_wr_en_b;
   logic [2:0] in_addr_b;
   logic [4:0] out_addr_b;
   logic [1:0] quad_b;

   logic busy_c, done_c, in_rd_en_c, out_wr_en_c;
   logic [0:0] in_addr_c;
   logic [2:0] out_addr_c;
   logic [1:0] quad_c;

   int n_pass = 0;
   int n_total = 0;

   int reads, writes, done_k, overlap, stall_bad;
   int rd_addr [64];
   int wr_addr [256];
   int wr_quad [256];
   logic post_busy, post_done;

   always #5 clk = ~clk;

   upsample_ctrl_param dut_a (
      .clk(clk), .rst(rst), .start(start_a), .out_ready(out_ready),
      .busy(busy_a), .done(done_a), .in_rd_en(in_rd_en_a), .in_addr(in_addr_a),
      .out_wr_en(out_wr_en_a), .out_addr(out_addr_a), .quad(quad_a));

   upsample_ctrl_param #(.IMG_W(3), .IMG_H(2), .CH(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .out_ready(out_ready),
      .busy(busy_b), .done(done_b), .in_rd_en(in_rd_en_b), .in_addr(in_addr_b),
      .out_wr_en(out_wr_en_b), .out_addr(out_addr_b), .quad(quad_b));

   upsample_ctrl_param #(.IMG_W(1), .IMG_H(1), .CH(1)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .out_ready(out_ready),
      .busy(busy_c), .done(done_c), .in_rd_en(in_rd_en_c), .in_addr(in_addr_c),
      .out_wr_en(out_wr_en_c), .out_addr(out_addr_c), .quad(quad_c));

   // Independent reference for the default geometry (4x4x2): counts read/write sequence errors
   function automatic int model_errs();
      int e = 0;
      for (int ch = 0; ch < 2; ch++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               int p = ch * 16 + r * 4 + c;
               if (rd_addr[p] != p) e++;
               for (int q = 0; q < 4; q++) begin
                  int exp_a = ch * 64 + (2 * r + q / 2) * 8 + 2 * c + (q % 2);
                  if (wr_addr[p * 4 + q] != exp_a || wr_quad[p * 4 + q] != q) e++;
               end
            end
      return e;
   endfunction

   // One run on dut_a; cycle 0 is the start cycle. Optional out_ready stall window.
   task automatic run_a(input int stall_k, input int stall_n, input bit hold);
      reads = 0; writes = 0; done_k = -1; overlap = 0; stall_bad = 0;
      post_busy = 1'b1; post_done = 1'b1;
      @(negedge clk);
      start_a = 1'b1; out_ready = 1'b1;
      for (int k = 1; k < 600; k++) begin
         @(negedge clk);
         if (!hold) start_a = 1'b0;
         out_ready = !(k >= stall_k && k < stall_k + stall_n);
         if (done_k >= 0) begin
            start_a = 1'b0;
            #1;
            post_busy = busy_a;
            post_done = done_a;
            break;
         end
         #1;
         if (in_rd_en_a && out_wr_en_a) overlap++;
         if (in_rd_en_a) begin
            if (reads < 64) rd_addr[reads] = int'(in_addr_a);
            reads++;
         end
         if (out_wr_en_a) begin
            if (writes < 256) begin
               wr_addr[writes] = int'(out_addr_a);
               wr_quad[writes] = int'(quad_a);
            end
            writes++;
         end
         if (!out_ready && (out_wr_en_a || quad_a != 2'd2 || out_addr_a != 7'd8 || !busy_a))
            stall_bad++;
         if (done_a) done_k = k;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_a = 1'b1; start_b = 1'b0; start_c = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_total++;
      if ({busy_a, done_a, in_rd_en_a, out_wr_en_a} !== 4'b0000) $display("FAIL reset_strobes got %b want 0000", {busy_a, done_a, in_rd_en_a, out_wr_en_a});
      else n_pass++;
      n_total++;
      if (in_addr_a !== 5'd0 || out_addr_a !== 7'd0 || quad_a !== 2'd0) $display("FAIL reset_addr got %0d/%0d/%0d want 0/0/0", in_addr_a, out_addr_a, quad_a);
      else n_pass++;
      n_total++;
      if (busy_b !== 1'b0 || busy_c !== 1'b0) $display("FAIL reset_busy_bc got %b%b want 00", busy_b, busy_c);
      else n_pass++;
      rst = 1'b0; start_a = 1'b0;
      @(negedge clk);
      #1;
      n_total++;
      if (busy_a !== 1'b0) $display("FAIL start_during_rst got busy=%b want 0", busy_a);
      else n_pass++;
   endtask

   task automatic test_full_run();
      run_a(0, 0, 1'b0);
      n_total++; if (reads != 32) $display("FAIL full_reads got %0d want 32", reads); else n_pass++;
      n_total++; if (writes != 128) $display("FAIL full_writes got %0d want 128", writes); else n_pass++;
      n_total++; if (done_k != 161) $display("FAIL full_done_cycle got %0d want 161", done_k); else n_pass++;
      n_total++; if (overlap != 0) $display("FAIL full_overlap got %0d want 0", overlap); else n_pass++;
      n_total++; if (model_errs() != 0) $display("FAIL full_model got %0d errors want 0", model_errs()); else n_pass++;
      n_total++;
      if (rd_addr[0] != 0 || wr_addr[0] != 0 || wr_addr[1] != 1 || wr_addr[2] != 8 || wr_addr[3] != 9 || wr_quad[3] != 3)
         $display("FAIL first_pixel got %0d:%0d,%0d,%0d,%0d want 0:0,1,8,9", rd_addr[0], wr_addr[0], wr_addr[1], wr_addr[2], wr_addr[3]);
      else n_pass++;
      n_total++;
      if (rd_addr[3] != 3 || wr_addr[12] != 6 || wr_addr[13] != 7 || wr_addr[14] != 14 || wr_addr[15] != 15)
         $display("FAIL pixel_003 got %0d:%0d,%0d,%0d,%0d want 3:6,7,14,15", rd_addr[3], wr_addr[12], wr_addr[13], wr_addr[14], wr_addr[15]);
      else n_pass++;
      n_total++;
      if (rd_addr[16] != 16 || wr_addr[64] != 64 || wr_addr[65] != 65 || wr_addr[66] != 72 || wr_addr[67] != 73)
         $display("FAIL pixel_100 got %0d:%0d,%0d,%0d,%0d want 16:64,65,72,73", rd_addr[16], wr_addr[64], wr_addr[65], wr_addr[66], wr_addr[67]);
      else n_pass++;
      n_total++;
      if (rd_addr[31] != 31 || wr_addr[124] != 118 || wr_addr[125] != 119 || wr_addr[126] != 126 || wr_addr[127] != 127)
         $display("FAIL last_pixel got %0d:%0d,%0d,%0d,%0d want 31:118,119,126,127", rd_addr[31], wr_addr[124], wr_addr[125], wr_addr[126], wr_addr[127]);
      else n_pass++;
      n_total++;
      if (post_busy !== 1'b0 || post_done !== 1'b0) $display("FAIL after_fin got busy=%b done=%b want 0 0", post_busy, post_done);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      run_a(4, 3, 1'b0);
      n_total++; if (done_k != 164) $display("FAIL bp_done_cycle got %0d want 164", done_k); else n_pass++;
      n_total++; if (stall_bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", stall_bad); else n_pass++;
      n_total++; if (writes != 128) $display("FAIL bp_writes got %0d want 128", writes); else n_pass++;
      n_total++;
      if (wr_addr[2] != 8 || wr_quad[2] != 2 || wr_addr[3] != 9 || wr_quad[3] != 3)
         $display("FAIL bp_resume got %0d/q%0d,%0d/q%0d want 8/q2,9/q3", wr_addr[2], wr_quad[2], wr_addr[3], wr_quad[3]);
      else n_pass++;
      n_total++; if (model_errs() != 0) $display("FAIL bp_model got %0d errors want 0", model_errs()); else n_pass++;
   endtask

   task automatic test_start_hold();
      run_a(0, 0, 1'b1);
      n_total++; if (done_k != 161) $display("FAIL hold_done_cycle got %0d want 161", done_k); else n_pass++;
      n_total++; if (reads != 32) $display("FAIL hold_reads got %0d want 32", reads); else n_pass++;
      n_total++; if (post_busy !== 1'b0) $display("FAIL hold_retrigger got busy=%b want 0", post_busy); else n_pass++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start_a = 1'b1; out_ready = 1'b1;
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         start_a = 1'b0;
      end
      #1;
      n_total++;
      if (in_addr_a !== 5'd5 || out_wr_en_a !== 1'b1 || quad_a !== 2'd1)
         $display("FAIL mid_pixel5 got in=%0d wr=%b q=%0d want 5 1 1", in_addr_a, out_wr_en_a, quad_a);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if ({busy_a, done_a, in_rd_en_a, out_wr_en_a} !== 4'b0000 || in_addr_a !== 5'd0 || out_addr_a !== 7'd0 || quad_a !== 2'd0)
         $display("FAIL mid_reset got %b %0d %0d %0d want 0000 0 0 0", {busy_a, done_a, in_rd_en_a, out_wr_en_a}, in_addr_a, out_addr_a, quad_a);
      else n_pass++;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      #1;
      n_total++;
      if (in_rd_en_a !== 1'b1 || in_addr_a !== 5'd0 || busy_a !== 1'b1)
         $display("FAIL restart got rd=%b addr=%0d busy=%b want 1 0 1", in_rd_en_a, in_addr_a, busy_a);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_small();
      int seen [24];
      int rd = 0, wr = 0, bad = 0, dk = -1;
      for (int i = 0; i < 24; i++) seen[i] = 0;
      @(negedge clk);
      start_b = 1'b1; out_ready = 1'b1;
      for (int k = 1; k < 200; k++) begin
         @(negedge clk);
         start_b = (k >= 10 && k < 13);
         #1;
         if (in_rd_en_b) rd++;
         if (out_wr_en_b) begin
            wr++;
            if (out_addr_b < 5'd24) seen[int'(out_addr_b)]++;
            else bad++;
         end
         if (done_b) begin dk = k; break; end
      end
      for (int i = 0; i < 24; i++) if (seen[i] != 1) bad++;
      n_total++; if (rd != 6) $display("FAIL small_reads got %0d want 6", rd); else n_pass++;
      n_total++; if (wr != 24) $display("FAIL small_writes got %0d want 24", wr); else n_pass++;
      n_total++; if (bad != 0) $display("FAIL small_coverage got %0d bad want 0", bad); else n_pass++;
      n_total++; if (dk != 31) $display("FAIL small_done_cycle got %0d want 31", dk); else n_pass++;
      @(negedge clk);
      start_b = 1'b0;
      #1;
      n_total++; if (busy_b !== 1'b0) $display("FAIL small_idle got busy=%b want 0", busy_b); else n_pass++;
   endtask

   task automatic test_tiny();
      int bad = 0;
      @(negedge clk);
      start_c = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      #1;
      n_total++;
      if (in_rd_en_c !== 1'b1 || in_addr_c !== 1'b0) $display("FAIL tiny_read got rd=%b addr=%0d want 1 0", in_rd_en_c, in_addr_c);
      else n_pass++;
      for (int q = 0; q < 4; q++) begin
         @(negedge clk);
         #1;
         if (out_wr_en_c !== 1'b1 || int'(out_addr_c) != q || int'(quad_c) != q) bad++;
      end
      n_total++; if (bad != 0) $display("FAIL tiny_writes got %0d bad want 0", bad); else n_pass++;
      @(negedge clk);
      #1;
      n_total++; if (done_c !== 1'b1) $display("FAIL tiny_done got %b want 1", done_c); else n_pass++;
      @(negedge clk);
      #1;
      n_total++; if (busy_c !== 1'b0) $display("FAIL tiny_idle got busy=%b want 0", busy_c); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_backpressure();
      test_start_hold();
      test_reset_mid();
      test_small();
      test_tiny();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
